// File: rtl/comm_byte_fifo_if.sv
// Byte FIFO push/pop/status bundle. The master drives requests, the FIFO (slave)
// returns read data, occupancy and sticky error flags.
interface comm_byte_fifo_if #(
  parameter int BYTE_W = 8
) ();
  logic              clr;
  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              rd_en;
  logic [BYTE_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [BYTE_W-1:0] fifo_count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, fifo_count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, fifo_count, overflow, underflow
  );
endinterface

// File: rtl/comm_byte_fifo.sv
// Synchronous byte FIFO with registered read port, occupancy count and sticky
// overflow/underflow flags; simultaneous push+pop is accepted even when full.
module comm_byte_fifo #(
  parameter int BYTE_W     = 8,
  parameter int DEPTH_BITS = 4
) (
  input logic             sys_clk,
  input logic             sys_rst_n,
  comm_byte_fifo_if.slave bus
);
  localparam int                DEPTH     = 1 << DEPTH_BITS;
  localparam logic [BYTE_W-1:0] DEPTH_CNT = BYTE_W'(DEPTH);

  logic [BYTE_W-1:0]     mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0]     count_q, count_d;
  logic [BYTE_W-1:0]     rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty, push_acc, pop_acc;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside it.
  assign pop_acc  = bus.rd_en & ~empty;
  assign push_acc = bus.wr_en & (~full | pop_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (bus.clr) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + DEPTH_BITS'(1);
      end
      if (pop_acc) begin
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + DEPTH_BITS'(1);
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + BYTE_W'(1);
        2'b01:   count_d = count_q - BYTE_W'(1);
        default: count_d = count_q;
      endcase
      if (bus.wr_en & full & ~pop_acc) overflow_d = 1'b1;
      if (bus.rd_en & empty)           underflow_d = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is data-only: no reset, contents are don't-care until written.
  always_ff @(posedge sys_clk) begin
    if (push_acc && !bus.clr) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;
endmodule

// File: tb/tb_comm_byte_fifo.sv
// Directed bench for comm_byte_fifo: fill/drain, full and empty corner cases,
// pointer wrap, flush and asynchronous reset.
module tb_comm_byte_fifo;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  comm_byte_fifo_if #(.BYTE_W(8)) bus ();

  comm_byte_fifo #(.BYTE_W(8), .DEPTH_BITS(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request inputs; returns #1 after the edge with inputs idle.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.clr     = c;
    @(posedge sys_clk);
    #1;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr     = 1'b0;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clr     = 1'b0;

    // Reset state
    #12;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
    #11 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    // Single push/pop
    cyc(1, 8'hA5, 0, 0);
    chk("a5_count1", bus.fifo_count, 1);
    chk("a5_empty0", bus.empty, 0);
    chk("a5_no_valid", bus.rd_valid, 0);
    cyc(0, 8'h00, 1, 0);
    chk("a5_valid", bus.rd_valid, 1);
    chk("a5_data", bus.rd_data, 8'hA5);
    chk("a5_count0", bus.fifo_count, 0);
    cyc(0, 8'h00, 0, 0);
    chk("a5_valid_drop", bus.rd_valid, 0);
    chk("a5_data_hold", bus.rd_data, 8'hA5);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.fifo_count, 16);
    cyc(1, 8'hFF, 0, 0);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_count", bus.fifo_count, 16);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("drain_valid", bus.rd_valid, 1);
      chk("drain_data", bus.rd_data, i);
    end
    chk("drain_empty", bus.empty, 1);
    cyc(0, 8'h00, 0, 0);
    chk("ovf_sticky", bus.overflow, 1);
    cyc(0, 8'h00, 0, 1);
    chk("clr_ovf", bus.overflow, 0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h10 + i), 0, 0);
    cyc(1, 8'h55, 1, 0);
    chk("fullrw_data", bus.rd_data, 8'h10);
    chk("fullrw_valid", bus.rd_valid, 1);
    chk("fullrw_count", bus.fifo_count, 16);
    chk("fullrw_ovf", bus.overflow, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("fullrw_order", bus.rd_data, 8'h11 + i);
    end
    cyc(0, 8'h00, 1, 0);
    chk("fullrw_last55", bus.rd_data, 8'h55);
    chk("fullrw_empty", bus.empty, 1);

    // Simultaneous push/pop while empty: no fall-through
    cyc(1, 8'h3C, 1, 0);
    chk("emptyrw_udf", bus.underflow, 1);
    chk("emptyrw_valid", bus.rd_valid, 0);
    chk("emptyrw_count", bus.fifo_count, 1);
    cyc(0, 8'h00, 1, 0);
    chk("emptyrw_data", bus.rd_data, 8'h3C);
    chk("emptyrw_valid2", bus.rd_valid, 1);
    chk("emptyrw_count0", bus.fifo_count, 0);

    // Pointer wrap at constant occupancy 3
    cyc(0, 8'h00, 0, 1);
    chk("clr_udf", bus.underflow, 0);
    for (int i = 0; i < 3; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 40; i++) begin
      cyc(1, 8'(8'h83 + i), 1, 0);
      chk("wrap_data", bus.rd_data, 8'h80 + i);
      chk("wrap_count", bus.fifo_count, 3);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 1, 0);
      chk("wrap_tail", bus.rd_data, 8'hA8 + i);
    end
    chk("wrap_empty", bus.empty, 1);

    // Flush with count 7 and both sticky flags set
    cyc(0, 8'h00, 1, 0);
    for (int i = 0; i < 16; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    cyc(1, 8'hEE, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 8'h00, 1, 0);
    chk("preclr_count", bus.fifo_count, 7);
    chk("preclr_ovf", bus.overflow, 1);
    chk("preclr_udf", bus.underflow, 1);
    cyc(1, 8'h77, 1, 1);
    chk("clr_count", bus.fifo_count, 0);
    chk("clr_empty", bus.empty, 1);
    chk("clr_ovf2", bus.overflow, 0);
    chk("clr_udf2", bus.underflow, 0);
    chk("clr_valid", bus.rd_valid, 0);
    chk("clr_data_hold", bus.rd_data, 8'h48);

    // Asynchronous reset mid-burst
    cyc(1, 8'h60, 0, 0);
    cyc(1, 8'h61, 0, 0);
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h62;
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_empty", bus.empty, 1);
    chk("arst_full", bus.full, 0);
    chk("arst_data", bus.rd_data, 0);
    chk("arst_valid", bus.rd_valid, 0);
    bus.wr_en = 1'b0;
    #2 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    chk("post_rst_count", bus.fifo_count, 0);
    cyc(1, 8'hC3, 0, 0);
    cyc(0, 8'h00, 1, 0);
    chk("post_rst_data", bus.rd_data, 8'hC3);
    chk("post_rst_valid", bus.rd_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/comm_byte_fifo.md
COMM_BYTE_FIFO -- requirements
Module: comm_byte_fifo

Interface
REQ-001 SHALL have parameter BYTE_W, default 8, data and count width in bits.
REQ-002 SHALL have parameter DEPTH_BITS, default 4, giving depth DEPTH = 2^DEPTH_BITS = 16 entries; DEPTH SHALL be less than 2^BYTE_W.
REQ-003 SHALL have port sys_clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port clr  input  1  synchronous flush; highest priority after reset.
REQ-006 SHALL have port wr_en  input  1  push request.
REQ-007 SHALL have port wr_data  input  BYTE_W  push byte.
REQ-008 SHALL have port rd_en  input  1  pop request.
REQ-009 SHALL have port rd_data  output  BYTE_W  popped byte, registered.
REQ-010 SHALL have port rd_valid  output  1  one-cycle strobe qualifying rd_data.
REQ-011 SHALL have port full  output  1  count == DEPTH.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port fifo_count  output  BYTE_W  current occupancy, zero-extended; feeds the SPI state machine COMM_*_FIFO_COUNT register reads.
REQ-014 SHALL have port overflow  output  1  sticky: push attempted while full.
REQ-015 SHALL have port underflow  output  1  sticky: pop attempted while empty.

Function
REQ-016 SHALL store entries in a DEPTH x BYTE_W array with DEPTH_BITS-wide write and read pointers that wrap from DEPTH-1 to 0.
REQ-017 SHALL define accepted push = wr_en & (~full | rd_en_accepted) and accepted pop = rd_en & ~empty, both evaluated on pre-edge state.
REQ-018 SHALL, on an accepted push, write wr_data at the write pointer and advance it by one.
REQ-019 SHALL, on an accepted pop, register array[read pointer] into rd_data, assert rd_valid for exactly the following cycle, and advance the read pointer; read latency = 1 cycle from rd_en edge.
REQ-020 SHALL hold rd_data unchanged and drive rd_valid low in cycles with no accepted pop.
REQ-021 SHALL update fifo_count as +1 (push only), -1 (pop only), unchanged (both or neither), registered with pointers.
REQ-022 SHALL, when full and wr_en & rd_en in the same cycle, accept both: oldest byte popped, new byte written, count stays DEPTH, overflow not set.
REQ-023 SHALL, when empty and wr_en & rd_en in the same cycle, accept only the push (no fall-through), set underflow, rd_valid low next cycle, count becomes 1.
REQ-024 SHALL, on wr_en while full without accepted pop, discard wr_data, leave state unchanged, and set overflow.
REQ-025 SHALL, on rd_en while empty, leave state unchanged and set underflow.
REQ-026 SHALL keep overflow and underflow set until clr or reset.
REQ-027 SHALL, on clr high, zero pointers, fifo_count, overflow, underflow and rd_valid at that edge, ignoring wr_en/rd_en that cycle; rd_data holds; array contents need not be cleared.
REQ-028 SHALL derive full and empty combinationally from registered fifo_count only.

Reset
REQ-029 SHALL, while sys_rst_n low, force pointers = 0, fifo_count = 0, rd_data = 0, rd_valid = 0, overflow = 0, underflow = 0, hence empty = 1, full = 0.
REQ-030 SHALL abandon any in-progress push/pop on reset assertion mid-operation; first accepted operation occurs on the first rising edge after sys_rst_n is sampled high.

Verification
REQ-031 SHALL cover: reset release, push 0xA5 then pop -> rd_data = 0xA5 with rd_valid one cycle after rd_en, fifo_count 1 -> 0.
REQ-032 SHALL cover: push 0x00..0x0F (16 bytes) -> full = 1, fifo_count = 0x10; 17th push 0xFF -> overflow = 1, count stays 0x10; popping 16 returns 0x00..0x0F in order.
REQ-033 SHALL cover: while full, simultaneous push 0x55 and pop -> rd_data = oldest byte, count = 0x10, overflow = 0; 0x55 emerges last.
REQ-034 SHALL cover: while empty, simultaneous push 0x3C and pop -> underflow = 1, no rd_valid, count = 1; next pop returns 0x3C.
REQ-035 SHALL cover: pointer wrap, 40 interleaved push/pop pairs at occupancy 3 -> data order preserved, count constant 3.
REQ-036 SHALL cover: clr with count = 7 and sticky flags set -> count = 0, empty = 1, flags 0 next cycle; sys_rst_n pulsed low mid-burst -> all outputs at reset values asynchronously.
